// File: rtl/relobi_fault_ctrl.sv
// Fault controller for reliable-OBI decoder ports: counts correctable faults, escalates
// OK->WARN->(DRAIN->ISOLATED) per port. Optional first-fault log: RELOBI_FAULT_LOG_EN.
module relobi_fault_ctrl #(
    parameter int unsigned NumSrc   = 4,
    parameter int unsigned CntWidth = 8,
    parameter int unsigned CeThresh = 16,
    localparam int unsigned SrcW    = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumSrc-1:0][1:0]             fault_i,
    input  logic [NumSrc-1:0]                  idle_i,
    input  logic [NumSrc-1:0]                  clear_i,
    output logic [NumSrc-1:0][CntWidth-1:0]    ce_cnt_o,
    output logic [NumSrc-1:0][1:0]             state_o,
    output logic [NumSrc-1:0]                  isolate_o,
    output logic                               irq_o,
    output logic                               first_vld_o,
    output logic [SrcW-1:0]                    first_src_o,
    output logic                               first_ue_o
);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_WARN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ISO   = 2'd3
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0] Thresh = CntWidth'(CeThresh);

    state_e                state_q [NumSrc];
    state_e                state_d [NumSrc];
    logic [CntWidth-1:0]   cnt_q   [NumSrc];
    logic [CntWidth-1:0]   cnt_d   [NumSrc];
    logic [NumSrc-1:0]     isolate_q, isolate_d;
    logic                  irq_q, irq_d;

    // Per-port next state, counter and isolation; clear wins over that cycle's faults.
    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NumSrc; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            isolate_d[i] = 1'b0;
            if (clear_i[i]) begin
                state_d[i] = ST_OK;
                cnt_d[i]   = {CntWidth{1'b0}};
            end else begin
                if (fault_i[i][0] && (cnt_q[i] != CntMax)) begin
                    cnt_d[i] = cnt_q[i] + CntWidth'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
                case (state_q[i])
                    ST_OK: begin
                        if (fault_i[i][1]) begin
                            state_d[i] = ST_DRAIN;
                        end else if (fault_i[i][0] && (cnt_d[i] >= Thresh)) begin
                            state_d[i] = ST_WARN;
                        end else begin
                            state_d[i] = ST_OK;
                        end
                    end
                    ST_WARN: begin
                        if (fault_i[i][1]) begin
                            state_d[i] = ST_DRAIN;
                        end else begin
                            state_d[i] = ST_WARN;
                        end
                    end
                    // A UE seen while already idle still spends one cycle here.
                    ST_DRAIN: begin
                        if (idle_i[i]) begin
                            state_d[i] = ST_ISO;
                        end else begin
                            state_d[i] = ST_DRAIN;
                        end
                    end
                    ST_ISO:  state_d[i] = ST_ISO;
                    default: state_d[i] = ST_OK;
                endcase
            end
            isolate_d[i] = (state_d[i] == ST_DRAIN) || (state_d[i] == ST_ISO);
            irq_d        = irq_d | (state_d[i] != ST_OK);
        end
    end

    // Port state, counters and derived outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSrc; i++) begin
                state_q[i] <= ST_OK;
                cnt_q[i]   <= {CntWidth{1'b0}};
            end
            isolate_q <= {NumSrc{1'b0}};
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NumSrc; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            isolate_q <= isolate_d;
            irq_q     <= irq_d;
        end
    end

    for (genvar g = 0; g < NumSrc; g++) begin : g_out
        assign state_o[g]  = state_q[g];
        assign ce_cnt_o[g] = cnt_q[g];
    end
    assign isolate_o = isolate_q;
    assign irq_o     = irq_q;

`ifdef RELOBI_FAULT_LOG_EN
    logic            first_vld_q, first_vld_d;
    logic [SrcW-1:0] first_src_q, first_src_d;
    logic            first_ue_q, first_ue_d;
    logic            hit_s;
    logic [SrcW-1:0] hit_src_s;
    logic            hit_ue_s;

    // Lowest-index port with an unsuppressed fault; captured once until a full clear.
    always_comb begin
        hit_s       = 1'b0;
        hit_src_s   = {SrcW{1'b0}};
        hit_ue_s    = 1'b0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if ((fault_i[i] != 2'b00) && !clear_i[i]) begin
                hit_s     = 1'b1;
                hit_src_s = SrcW'(i);
                hit_ue_s  = fault_i[i][1];
            end else begin
                hit_s     = hit_s;
            end
        end
        first_vld_d = first_vld_q;
        first_src_d = first_src_q;
        first_ue_d  = first_ue_q;
        if (&clear_i) begin
            first_vld_d = 1'b0;
            first_src_d = {SrcW{1'b0}};
            first_ue_d  = 1'b0;
        end else if (!first_vld_q && hit_s) begin
            first_vld_d = 1'b1;
            first_src_d = hit_src_s;
            first_ue_d  = hit_ue_s;
        end else begin
            first_vld_d = first_vld_q;
        end
    end

    // First-fault log registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_vld_q <= 1'b0;
            first_src_q <= {SrcW{1'b0}};
            first_ue_q  <= 1'b0;
        end else begin
            first_vld_q <= first_vld_d;
            first_src_q <= first_src_d;
            first_ue_q  <= first_ue_d;
        end
    end

    assign first_vld_o = first_vld_q;
    assign first_src_o = first_src_q;
    assign first_ue_o  = first_ue_q;
`else
    assign first_vld_o = 1'b0;
    assign first_src_o = {SrcW{1'b0}};
    assign first_ue_o  = 1'b0;
`endif

endmodule

// File: tb/tb_relobi_fault_ctrl.sv
// Directed bench for relobi_fault_ctrl (NumSrc=4, CntWidth=8, CeThresh=16).
module tb_relobi_fault_ctrl;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0][1:0]  fault;
    logic [3:0]       idle;
    logic [3:0]       clear;
    logic [3:0][7:0]  cnt;
    logic [3:0][1:0]  state;
    logic [3:0]       isolate;
    logic             irq;
    logic             fvld;
    logic [1:0]       fsrc;
    logic             fue;

    int errors = 0;
    int checks = 0;

    relobi_fault_ctrl #(.NumSrc(4), .CntWidth(8), .CeThresh(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .idle_i(idle), .clear_i(clear),
        .ce_cnt_o(cnt), .state_o(state), .isolate_o(isolate), .irq_o(irq),
        .first_vld_o(fvld), .first_src_o(fsrc), .first_ue_o(fue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs applied before the edge are visible on outputs afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fault = '0;
        clear = '0;
        idle  = 4'b0000;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_cnt", cnt, 32'h0);
        chk("rst_state", state, 32'h0);
        rst_n = 1'b1;
        repeat (100) tick();
        // 1: quiet after reset
        chk("t1_cnt", cnt, 32'h0);
        chk("t1_state", state, 32'h0);
        chk("t1_iso", isolate, 32'h0);
        chk("t1_irq", irq, 32'h0);
        chk("t1_fvld", fvld, 32'h0);

        // 6: first-fault log (CE on ports 3 and 1)
        fault[3] = 2'b01; fault[1] = 2'b01;
        tick();
        fault = '0;
        chk("t6_cnt1", cnt[1], 32'd1);
        chk("t6_cnt3", cnt[3], 32'd1);
        chk("t6_irq_ce", irq, 32'h0);
`ifdef RELOBI_FAULT_LOG_EN
        chk("t6_fvld", fvld, 32'h1);
        chk("t6_fsrc", fsrc, 32'h1);
        chk("t6_fue", fue, 32'h0);
`else
        chk("t6_fvld_off", fvld, 32'h0);
        chk("t6_fsrc_off", fsrc, 32'h0);
`endif
        fault[0] = 2'b10;
        tick();
        fault = '0;
        chk("t6_st0", state[0], 32'd2);
        chk("t6_iso0", isolate, 32'h1);
        chk("t6_irq", irq, 32'h1);
`ifdef RELOBI_FAULT_LOG_EN
        chk("t6_fsrc_hold", fsrc, 32'h1);
        chk("t6_fue_hold", fue, 32'h0);
`endif
        clear = 4'hF;
        tick();
        clear = '0;
        chk("t6_clr_fvld", fvld, 32'h0);
        chk("t6_clr_state", state, 32'h0);
        chk("t6_clr_cnt", cnt, 32'h0);
        chk("t6_clr_irq", irq, 32'h0);

        // 2: port1 reaches WARN on the 16th CE
        fault[1] = 2'b01;
        repeat (15) tick();
        chk("t2_cnt15", cnt[1], 32'd15);
        chk("t2_st15", state[1], 32'd0);
        chk("t2_irq15", irq, 32'h0);
        tick();
        fault = '0;
        chk("t2_cnt16", cnt[1], 32'd16);
        chk("t2_warn", state[1], 32'd1);
        chk("t2_irq", irq, 32'h1);
        chk("t2_iso", isolate, 32'h0);

        // 5: clear beats UE on port3
        fault[3] = 2'b10; clear[3] = 1'b1;
        tick();
        idle_inputs();
        chk("t5_st3", state[3], 32'd0);
        chk("t5_cnt3", cnt[3], 32'd0);
        chk("t5_iso", isolate, 32'h0);
        chk("t5_irq", irq, 32'h1);

        // 3: port2 UE, drain 5 cycles, then isolate, then clear
        fault[2] = 2'b10;
        tick();
        fault = '0;
        chk("t3_drain", state[2], 32'd2);
        chk("t3_iso_d", isolate, 32'h4);
        repeat (4) tick();
        chk("t3_drain5", state[2], 32'd2);
        idle[2] = 1'b1;
        tick();
        chk("t3_isol", state[2], 32'd3);
        chk("t3_iso_i", isolate, 32'h4);
        fault[2] = 2'b01;
        tick();
        fault = '0;
        chk("t3_ce_isol", cnt[2], 32'd1);
        chk("t3_stay", state[2], 32'd3);
        clear[2] = 1'b1;
        tick();
        clear = '0;
        chk("t3_clr", state[2], 32'd0);
        chk("t3_clr_iso", isolate, 32'h0);
        chk("t3_clr_cnt", cnt[2], 32'd0);
        // UE while already idle: one DRAIN cycle first
        fault[2] = 2'b10;
        tick();
        fault = '0;
        chk("t3_idle_drain", state[2], 32'd2);
        tick();
        chk("t3_idle_isol", state[2], 32'd3);
        clear[2] = 1'b1;
        tick();
        idle_inputs();

        // 4: port0 saturation, CE+UE same cycle
        fault[0] = 2'b01;
        repeat (300) tick();
        fault = '0;
        chk("t4_sat", cnt[0], 32'd255);
        chk("t4_warn", state[0], 32'd1);
        fault[0] = 2'b11; fault[3] = 2'b11;
        tick();
        fault = '0;
        chk("t4_sat_ue", cnt[0], 32'd255);
        chk("t4_drain0", state[0], 32'd2);
        chk("t4_cnt3", cnt[3], 32'd1);
        chk("t4_drain3", state[3], 32'd2);
        chk("t4_iso", isolate, 32'h9);

        // clearing the last active ports drops irq
        clear = 4'b1011;
        tick();
        clear = '0;
        chk("irq_drop", irq, 32'h0);
        chk("irq_drop_state", state, 32'h0);

        // async reset mid-operation
        fault[1] = 2'b10;
        tick();
        fault = '0;
        chk("pre_rst_st", state[1], 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", state, 32'h0);
        chk("async_iso", isolate, 32'h0);
        chk("async_irq", irq, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
